multiport_ram_model: RTL and testbench

- Parametrised successor to the fixed 4-port, 1024-word simulation RAM that backs the CGRA memory units (mem_N_mem_unit_*).
- Generalised in port count, width, depth and read latency; selectable read-during-write mode; deterministic write-collision resolution with error reporting.
- Adds a host port, used by the testbench or a future loader, for preload and readback, plus a hardware clear engine.
- Sits between the cgra_U0 memory-unit ports and the testbench. It replaces the fixed model; nothing is instantiated inside the CGRA itself.

---
 rtl/mem_model_pkg.sv | 25 ++
 rtl/ram_read_pipe.sv | 37 +++
 rtl/multiport_ram_model.sv | 194 +++++++++++++++++++
 tb/tb_multiport_ram_model.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_model_pkg.sv
// Shared types, constants and address translation for the multiport RAM model.
package mem_model_pkg;

  localparam int COLLIDE_CNT_W = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clear_state_t;

  // Byte addresses drop the byte-offset bits of a word; word addresses pass through.
  // The result is kept at full width so callers can detect out-of-range indices.
  function automatic logic [63:0] addr_to_index(input logic [63:0] addr,
                                                input int byte_addr,
                                                input int data_w);
    logic [63:0] idx;
    if (byte_addr != 32'sd0) begin
      idx = addr >> $clog2(data_w / 32'sd8);
    end else begin
      idx = addr;
    end
    return idx;
  endfunction

endpackage

// File: rtl/ram_read_pipe.sv
// Fixed-latency data + valid shift register that delays one read sample.
module ram_read_pipe #(
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clock,
  input  logic              sync_reset_n,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0]  data_r [LATENCY];
  logic [LATENCY-1:0] valid_r;

  // Advance each sample and its valid flag one stage per cycle; reset flushes.
  always_ff @(posedge clock) begin
    if (!sync_reset_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        data_r[i] <= '0;
      end
      valid_r <= '0;
    end else begin
      data_r[0]  <= data_in;
      valid_r[0] <= valid_in;
      for (int i = 1; i < LATENCY; i++) begin
        data_r[i]  <= data_r[i-1];
        valid_r[i] <= valid_r[i-1];
      end
    end
  end

  assign valid_out = valid_r[LATENCY-1];
  assign data_out  = data_r[LATENCY-1];

endmodule

// File: rtl/multiport_ram_model.sv
// Parametrised multiport simulation RAM backing the CGRA memory units, with a
// host preload/readback port, a hardware clear engine and collision/range flags.
module multiport_ram_model
  import mem_model_pkg::*;
#(
  parameter int NUM_PORTS    = 4,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_FIRST  = 0,
  parameter int BYTE_ADDR    = 1
) (
  input  logic                          clock,
  input  logic                          sync_reset_n,
  input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   data_in,
  input  logic [NUM_PORTS-1:0]          w_rq,
  output logic [NUM_PORTS*DATA_W-1:0]   data_out,
  input  logic                          host_valid,
  input  logic                          host_we,
  input  logic [ADDR_W-1:0]             host_addr,
  input  logic [DATA_W-1:0]             host_wdata,
  output logic                          host_ready,
  output logic                          host_rvalid,
  output logic [DATA_W-1:0]             host_rdata,
  input  logic                          clear_start,
  output logic                          clear_busy,
  output logic                          oob_err,
  output logic                          collide_err,
  output logic [COLLIDE_CNT_W-1:0]      collide_cnt
);

  localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Requesters 0..NUM_PORTS-1 are the CGRA ports; index NUM_PORTS is the host.
  localparam int          NW       = NUM_PORTS + 1;
  localparam logic [63:0] DEPTH_64 = 64'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem_r [DEPTH];

  clear_state_t      state_r;
  logic [IDX_W-1:0]  clr_cnt_r;

  logic [63:0]       index_s   [NW];
  logic [IDX_W-1:0]  idx_s     [NW];
  logic [DATA_W-1:0] w_data_s  [NW];
  logic [DATA_W-1:0] rd_data_s [NW];
  logic [DATA_W-1:0] pipe_data_s [NW];
  logic [NW-1:0]     oob_s;
  logic [NW-1:0]     w_en_s;
  logic [NW-1:0]     rd_req_s;
  logic [NW-1:0]     pipe_valid_s;
  logic              host_acc_s;
  logic              collide_s;
  logic              oob_hit_s;

  assign clear_busy = (state_r == CLEAR);
  assign host_ready = !clear_busy;

  // Translate every address and form per-requester write enables and range flags.
  always_comb begin
    host_acc_s = host_valid && host_ready;
    for (int p = 0; p < NUM_PORTS; p++) begin
      index_s[p]  = addr_to_index(64'(addr[p*ADDR_W +: ADDR_W]), BYTE_ADDR, DATA_W);
      w_data_s[p] = data_in[p*DATA_W +: DATA_W];
      rd_req_s[p] = 1'b1;
    end
    index_s[NUM_PORTS]  = addr_to_index(64'(host_addr), BYTE_ADDR, DATA_W);
    w_data_s[NUM_PORTS] = host_wdata;
    rd_req_s[NUM_PORTS] = host_acc_s && !host_we;
    for (int i = 0; i < NW; i++) begin
      oob_s[i] = (index_s[i] >= DEPTH_64);
      idx_s[i] = index_s[i][IDX_W-1:0];
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_en_s[p] = w_rq[p] && !oob_s[p] && !clear_busy;
    end
    w_en_s[NUM_PORTS] = host_acc_s && host_we && !oob_s[NUM_PORTS];
  end

  // Detect same-word write collisions and out-of-range accesses this cycle.
  always_comb begin
    collide_s = 1'b0;
    for (int i = 0; i < NW; i++) begin
      for (int j = i + 1; j < NW; j++) begin
        collide_s = collide_s | (w_en_s[i] & w_en_s[j] & (idx_s[i] == idx_s[j]));
      end
    end
    oob_hit_s = (|oob_s[NUM_PORTS-1:0]) | (oob_s[NUM_PORTS] & host_acc_s);
  end

  // Form each read sample: stored word, optional write-first bypass, then masking.
  always_comb begin
    for (int r = 0; r < NW; r++) begin
      rd_data_s[r] = mem_r[idx_s[r]];
      // Scan from lowest priority upwards so the winning writer is applied last.
      for (int w = NW - 1; w >= 0; w--) begin
        rd_data_s[r] = ((WRITE_FIRST != 0) && w_en_s[w] && (idx_s[w] == idx_s[r]))
                       ? w_data_s[w] : rd_data_s[r];
      end
      rd_data_s[r] = oob_s[r] ? '0 : rd_data_s[r];
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      rd_data_s[p] = clear_busy ? '0 : rd_data_s[p];
    end
  end

  // Commit writes; the clear engine owns storage while busy. Storage is never reset.
  always_ff @(posedge clock) begin
    if (state_r == CLEAR) begin
      if (sync_reset_n) begin
        mem_r[clr_cnt_r] <= '0;
      end else begin
        mem_r[clr_cnt_r] <= mem_r[clr_cnt_r];
      end
    end else begin
      // Lowest-numbered writer is assigned last and therefore wins.
      for (int w = NW - 1; w >= 0; w--) begin
        if (w_en_s[w]) begin
          mem_r[idx_s[w]] <= w_data_s[w];
        end
      end
    end
  end

  // Clear FSM, sticky error flags and saturating collision counter.
  always_ff @(posedge clock) begin
    if (!sync_reset_n) begin
      state_r     <= IDLE;
      clr_cnt_r   <= '0;
      oob_err     <= 1'b0;
      collide_err <= 1'b0;
      collide_cnt <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (clear_start) begin
            state_r   <= CLEAR;
            clr_cnt_r <= '0;
          end else begin
            state_r   <= IDLE;
            clr_cnt_r <= clr_cnt_r;
          end
        end
        CLEAR: begin
          if (clr_cnt_r == LAST_IDX) begin
            state_r   <= IDLE;
            clr_cnt_r <= '0;
          end else begin
            state_r   <= CLEAR;
            clr_cnt_r <= clr_cnt_r + 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          clr_cnt_r <= '0;
        end
      endcase
      oob_err     <= oob_err | oob_hit_s;
      collide_err <= collide_err | collide_s;
      if (collide_s && (collide_cnt != {COLLIDE_CNT_W{1'b1}})) begin
        collide_cnt <= collide_cnt + 1'b1;
      end else begin
        collide_cnt <= collide_cnt;
      end
    end
  end

  for (genvar r = 0; r < NW; r++) begin : g_pipe
    ram_read_pipe #(
      .DATA_W  (DATA_W),
      .LATENCY (READ_LATENCY)
    ) u_pipe (
      .clock        (clock),
      .sync_reset_n (sync_reset_n),
      .valid_in     (rd_req_s[r]),
      .data_in      (rd_data_s[r]),
      .valid_out    (pipe_valid_s[r]),
      .data_out     (pipe_data_s[r])
    );
  end

  // Present pipeline outputs; stages not yet filled since reset read as zero.
  always_comb begin
    data_out = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      data_out[p*DATA_W +: DATA_W] = pipe_valid_s[p] ? pipe_data_s[p] : '0;
    end
    host_rvalid = pipe_valid_s[NUM_PORTS];
    host_rdata  = pipe_valid_s[NUM_PORTS] ? pipe_data_s[NUM_PORTS] : '0;
  end

endmodule

// File: tb/tb_multiport_ram_model.sv
// Directed bench: default-configured RAM (read-first, latency 1) and a
// write-first, latency-3, 64-word RAM sharing one clock and reset.
module tb_multiport_ram_model;
  localparam int NP = 4;
  localparam int DW = 32;
  localparam int AW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [NP*AW-1:0] a_addr, b_addr;
  logic [NP*DW-1:0] a_din, b_din, a_dout, b_dout;
  logic [NP-1:0]    a_wrq, b_wrq;
  logic             a_hv, a_hwe, a_hrdy, a_hrv, a_cs, a_cb, a_oob, a_cerr;
  logic             b_hv, b_hwe, b_hrdy, b_hrv, b_cs, b_cb, b_oob, b_cerr;
  logic [AW-1:0]    a_haddr, b_haddr;
  logic [DW-1:0]    a_hwd, b_hwd, a_hrd, b_hrd;
  logic [15:0]      a_ccnt, b_ccnt;

  multiport_ram_model dut_a (
    .clock(clk), .sync_reset_n(rst_n), .addr(a_addr), .data_in(a_din), .w_rq(a_wrq),
    .data_out(a_dout), .host_valid(a_hv), .host_we(a_hwe), .host_addr(a_haddr),
    .host_wdata(a_hwd), .host_ready(a_hrdy), .host_rvalid(a_hrv), .host_rdata(a_hrd),
    .clear_start(a_cs), .clear_busy(a_cb), .oob_err(a_oob), .collide_err(a_cerr),
    .collide_cnt(a_ccnt));

  multiport_ram_model #(.DEPTH(64), .READ_LATENCY(3), .WRITE_FIRST(1)) dut_b (
    .clock(clk), .sync_reset_n(rst_n), .addr(b_addr), .data_in(b_din), .w_rq(b_wrq),
    .data_out(b_dout), .host_valid(b_hv), .host_we(b_hwe), .host_addr(b_haddr),
    .host_wdata(b_hwd), .host_ready(b_hrdy), .host_rvalid(b_hrv), .host_rdata(b_hrd),
    .clear_start(b_cs), .clear_busy(b_cb), .oob_err(b_oob), .collide_err(b_cerr),
    .collide_cnt(b_ccnt));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  typedef struct {
    logic [NP-1:0]         wrq;
    logic [NP-1:0][AW-1:0] addr;   // {p3,p2,p1,p0}
    logic [NP-1:0][DW-1:0] din;
    logic [NP-1:0]         chk;
    logic [NP-1:0][DW-1:0] exp;
    logic [15:0]           exp_cnt;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int hr_bad;
    vecs[0] = '{wrq:4'b0001, addr:{32'h0, 32'h0, 32'h0, 32'hC00}, din:{32'h0, 32'h0, 32'h0, 32'hDEADBEEF},
                chk:4'b0000, exp:{32'h0, 32'h0, 32'h0, 32'h0}, exp_cnt:16'd0};
    vecs[1] = '{wrq:4'b0000, addr:{32'h0, 32'h0, 32'hC00, 32'h0}, din:{32'h0, 32'h0, 32'h0, 32'h0},
                chk:4'b0010, exp:{32'h0, 32'h0, 32'hDEADBEEF, 32'h0}, exp_cnt:16'd0};
    vecs[2] = '{wrq:4'b1100, addr:{32'h40, 32'h40, 32'h0, 32'h0}, din:{32'h22, 32'h11, 32'h0, 32'h0},
                chk:4'b0000, exp:{32'h0, 32'h0, 32'h0, 32'h0}, exp_cnt:16'd1};
    vecs[3] = '{wrq:4'b0010, addr:{32'h0, 32'hC00, 32'h8, 32'h40}, din:{32'h0, 32'h0, 32'h7, 32'h0},
                chk:4'b0101, exp:{32'h0, 32'hDEADBEEF, 32'h0, 32'h11}, exp_cnt:16'd1};
    vecs[4] = '{wrq:4'b0001, addr:{32'h0, 32'h0, 32'h8, 32'h8}, din:{32'h0, 32'h0, 32'h0, 32'h55},
                chk:4'b0011, exp:{32'h0, 32'h0, 32'h7, 32'h7}, exp_cnt:16'd1};
    vecs[5] = '{wrq:4'b0011, addr:{32'h8, 32'h0, 32'h10, 32'h10}, din:{32'h0, 32'h0, 32'hB, 32'hA},
                chk:4'b1000, exp:{32'h55, 32'h0, 32'h0, 32'h0}, exp_cnt:16'd2};
    vecs[6] = '{wrq:4'b1110, addr:{32'h100, 32'h100, 32'h100, 32'h10}, din:{32'h3, 32'h2, 32'h1, 32'h0},
                chk:4'b0001, exp:{32'h0, 32'h0, 32'h0, 32'hA}, exp_cnt:16'd3};
    vecs[7] = '{wrq:4'b0000, addr:{32'h100, 32'h0, 32'h0, 32'h0}, din:{32'h0, 32'h0, 32'h0, 32'h0},
                chk:4'b1000, exp:{32'h1, 32'h0, 32'h0, 32'h0}, exp_cnt:16'd3};
    vecs[8] = '{wrq:4'b0011, addr:{32'h0, 32'h0, 32'h204, 32'h200}, din:{32'h0, 32'h0, 32'h2, 32'h1},
                chk:4'b0000, exp:{32'h0, 32'h0, 32'h0, 32'h0}, exp_cnt:16'd3};
    vecs[9] = '{wrq:4'b0000, addr:{32'h204, 32'h200, 32'h0, 32'h0}, din:{32'h0, 32'h0, 32'h0, 32'h0},
                chk:4'b1100, exp:{32'h2, 32'h1, 32'h0, 32'h0}, exp_cnt:16'd3};

    rst_n = 1'b0;
    a_addr = '0; a_din = '0; a_wrq = '0; a_hv = 1'b0; a_hwe = 1'b0; a_haddr = '0; a_hwd = '0; a_cs = 1'b0;
    b_addr = '0; b_din = '0; b_wrq = '0; b_hv = 1'b0; b_hwe = 1'b0; b_haddr = '0; b_hwd = '0; b_cs = 1'b0;
    tick(); tick();

    // Reset state
    check("rst a_dout", 32'(a_dout != '0), 32'd0);
    check("rst b_dout", 32'(b_dout != '0), 32'd0);
    check("rst a_hrv", 32'(a_hrv), 32'd0);
    check("rst a_cb", 32'(a_cb), 32'd0);
    check("rst a_flags", {29'd0, a_oob, a_cerr, b_oob}, 32'd0);
    check("rst a_ccnt", 32'(a_ccnt), 32'd0);
    rst_n = 1'b1;

    // Table: read-first latency-1 traffic, collisions and priority
    for (int i = 0; i < 10; i++) begin
      a_wrq = vecs[i].wrq; a_addr = vecs[i].addr; a_din = vecs[i].din;
      tick();
      for (int p = 0; p < NP; p++) begin
        if (vecs[i].chk[p]) begin
          check($sformatf("vec%0d dout%0d", i, p), a_dout[p*DW +: DW], vecs[i].exp[p]);
        end
      end
      check($sformatf("vec%0d collide_cnt", i), 32'(a_ccnt), 32'(vecs[i].exp_cnt));
      check($sformatf("vec%0d collide_err", i), 32'(a_cerr), 32'(vecs[i].exp_cnt != 16'd0));
      check($sformatf("vec%0d oob_err", i), 32'(a_oob), 32'd0);
    end
    a_wrq = '0; a_addr = '0; a_din = '0;

    // Host write then read on latency-1 RAM; CGRA port 0 sees the same word
    a_hv = 1'b1; a_hwe = 1'b1; a_haddr = 32'h0; a_hwd = 32'd16;
    check("a host_ready idle", 32'(a_hrdy), 32'd1);
    tick();
    a_hwe = 1'b0;
    tick();
    a_hv = 1'b0;
    check("a host_rvalid", 32'(a_hrv), 32'd1);
    check("a host_rdata", a_hrd, 32'd16);
    check("a port0 after host wr", a_dout[DW-1:0], 32'd16);
    tick();
    check("a host_rvalid pulse", 32'(a_hrv), 32'd0);

    // Out-of-range access: word 1024 must not alias onto word 0
    a_addr[AW-1:0] = 32'h1000; a_wrq = 4'b0001; a_din[DW-1:0] = 32'hFFFF;
    tick();
    check("oob read data", a_dout[DW-1:0], 32'd0);
    check("oob_err set", 32'(a_oob), 32'd1);
    a_addr = '0; a_wrq = '0; a_din = '0;
    tick();
    check("oob no alias write", a_dout[DW-1:0], 32'd16);
    check("oob_err sticky", 32'(a_oob), 32'd1);

    // Write-first, latency 3: port1 reads addr 0 while port0 writes it
    b_wrq = 4'b0001; b_din[DW-1:0] = 32'h7;
    tick();
    b_wrq = '0;
    tick();
    b_wrq = 4'b0001; b_din[DW-1:0] = 32'h55;
    tick();
    b_wrq = '0;
    check("b lat3 wf sample0", b_dout[DW +: DW], 32'h7);
    tick();
    check("b lat3 sample1", b_dout[DW +: DW], 32'h7);
    tick();
    check("b lat3 wf 0x55", b_dout[DW +: DW], 32'h55);

    // Host vs CGRA write to one word: CGRA wins, write-first read sees winner
    b_hv = 1'b1; b_hwe = 1'b1; b_haddr = 32'h20; b_hwd = 32'h33;
    b_wrq = 4'b1000; b_addr[3*AW +: AW] = 32'h20; b_din[3*DW +: DW] = 32'h44;
    b_addr[2*AW +: AW] = 32'h20;
    tick();
    check("b host collide cnt", 32'(b_ccnt), 32'd1);
    check("b host collide err", 32'(b_cerr), 32'd1);
    b_hwe = 1'b0; b_wrq = '0; b_addr = '0; b_din = '0;
    tick();
    b_hv = 1'b0;
    check("b host rvalid lat1", 32'(b_hrv), 32'd0);
    tick();
    check("b host rvalid lat2", 32'(b_hrv), 32'd0);
    check("b port2 wf winner", b_dout[2*DW +: DW], 32'h44);
    tick();
    check("b host rvalid lat3", 32'(b_hrv), 32'd1);
    check("b host rdata winner", b_hrd, 32'h44);
    tick();
    check("b host rvalid pulse", 32'(b_hrv), 32'd0);

    // Full clear: 1024 busy cycles, host blocked, CGRA reads 0 / writes ignored
    a_cs = 1'b1;
    tick();
    a_cs = 1'b0;
    check("clear busy start", 32'(a_cb), 32'd1);
    cyc = 0; hr_bad = 0;
    while (a_cb && cyc < 2000) begin
      if (a_hrdy) hr_bad++;
      a_cs = (cyc == 10);
      if (cyc == 5) begin
        a_addr[AW-1:0] = 32'h204; a_addr[AW +: AW] = 32'h8; a_wrq = 4'b0010; a_din[DW +: DW] = 32'h99;
      end else if (cyc == 6) begin
        check("clear cgra read zero", a_dout[DW-1:0], 32'd0);
        a_addr = '0; a_wrq = '0; a_din = '0;
      end
      tick();
      cyc++;
    end
    a_cs = 1'b0;
    check("clear busy cycles", 32'(cyc), 32'd1024);
    check("clear host_ready low", 32'(hr_bad), 32'd0);
    check("host_ready after clear", 32'(a_hrdy), 32'd1);
    a_addr = {32'h100, 32'h40, 32'h8, 32'hC00};
    tick();
    for (int p = 0; p < NP; p++) check($sformatf("cleared set1 p%0d", p), a_dout[p*DW +: DW], 32'd0);
    a_addr = {32'h204, 32'h200, 32'h10, 32'h0};
    tick();
    for (int p = 0; p < NP; p++) check($sformatf("cleared set2 p%0d", p), a_dout[p*DW +: DW], 32'd0);

    // Partial clear aborted by reset at clear cycle 100
    a_wrq = 4'b1111; a_addr = {32'h7D0, 32'h194, 32'h190, 32'hC8};
    a_din = {32'hA4, 32'hA3, 32'hA2, 32'hA1};
    tick();
    a_wrq = '0; a_din = '0; a_addr = '0;
    a_cs = 1'b1;
    tick();
    a_cs = 1'b0;
    repeat (100) tick();
    check("abort busy at 100", 32'(a_cb), 32'd1);
    rst_n = 1'b0;
    tick();
    check("abort busy dropped", 32'(a_cb), 32'd0);
    check("abort flags reset", {30'd0, a_oob, a_cerr}, 32'd0);
    check("abort ccnt reset", 32'(a_ccnt), 32'd0);
    rst_n = 1'b1;
    a_addr = {32'h7D0, 32'h194, 32'h190, 32'hC8};
    tick();
    check("abort word50 cleared", a_dout[DW-1:0], 32'd0);
    check("abort word100 kept", a_dout[DW +: DW], 32'hA2);
    check("abort word101 kept", a_dout[2*DW +: DW], 32'hA3);
    check("abort word500 kept", a_dout[3*DW +: DW], 32'hA4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
